// File: rtl/chan_select_rr.sv
// N-channel registered channel selector with fixed-select and round-robin modes.
// Valid/ready on every input and on the single one-entry output register.
module chan_select_rr #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic            accept;
  logic            fix_vld;
  logic [SELW-1:0] fix_idx;
  logic            rr_vld;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_next;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic [N-1:0]    grant_oh;
  logic [W-1:0]    grant_data;

  assign accept = !out_valid || out_ready;

  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    fix_vld = 1'b0;
    fix_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (sel == SELW'(j) && in_valid[j]) begin
        fix_vld = 1'b1;
        fix_idx = SELW'(j);
      end
    end
  end

  // Walk channels starting at rr_ptr; first valid one wins.
  always_comb begin
    int pos;
    pos    = 0;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N) pos = pos - N;
      for (int j = 0; j < N; j++) begin
        if (!rr_vld && j == pos && in_valid[j]) begin
          rr_vld = 1'b1;
          rr_idx = SELW'(j);
        end
      end
    end
  end

  always_comb begin
    grant_vld = accept && !reset && (mode ? rr_vld : fix_vld);
    grant_idx = mode ? rr_idx : fix_idx;
  end

  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int j = 0; j < N; j++) begin
      grant_oh[j] = grant_vld && (grant_idx == SELW'(j));
      if (grant_oh[j]) grant_data = in_data[j*W +: W];
    end
  end

  assign in_ready = grant_oh;

  assign rr_next = (rr_idx == SELW'(N-1)) ? '0 : rr_idx + SELW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (grant_vld) begin
        out_data  <= grant_data;
        out_chan  <= grant_idx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Fixed-mode grants leave the scan position alone.
      if (grant_vld && mode) rr_ptr <= rr_next;
    end
  end

endmodule
